// File: rtl/leg_mem_pkg.sv
// Shared types and constants for the data-memory initiator: access sizes,
// FSM states, lane masks and size/alignment helpers.
package leg_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } mem_size_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_RMW_WR = 3'd3,
      ST_WRITE  = 3'd4,
      ST_RESP   = 3'd5
   } dmem_init_state_e;

   localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
   localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
   localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

   function automatic logic is_subword(input mem_size_e size);
      return (size == SZ_BYTE) || (size == SZ_HALF);
   endfunction

   // Reserved size behaves as a word, so it shares the word alignment rule.
   function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lo[0];
         SZ_WORD: mis = (lo != 2'b00);
         SZ_RSVD: mis = (lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling: extracts and extends load data from a memory
// word, and merges sub-word store data into a word for read-modify-write.
module dmem_lane_align
   import leg_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  mem_size_e   size,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [4:0]  shift_s;
   logic [31:0] mask_s;
   logic [31:0] lane_s;

   // Select the lane shift/mask, then extend for loads and splice for stores.
   always_comb begin
      shift_s   = 5'd0;
      mask_s    = LANE_MASK_WORD;
      lane_s    = word;
      load_data = word;
      case (size)
         SZ_BYTE: begin
            shift_s   = {addr_lo, 3'b000};
            mask_s    = LANE_MASK_BYTE;
            lane_s    = word >> shift_s;
            load_data = {{24{sign_ext & lane_s[7]}}, lane_s[7:0]};
         end
         SZ_HALF: begin
            shift_s   = {addr_lo[1], 4'b0000};
            mask_s    = LANE_MASK_HALF;
            lane_s    = word >> shift_s;
            load_data = {{16{sign_ext & lane_s[15]}}, lane_s[15:0]};
         end
         default: begin
            shift_s   = 5'd0;
            mask_s    = LANE_MASK_WORD;
            lane_s    = word;
            load_data = word;
         end
      endcase
      merge_data = (word & ~(mask_s << shift_s)) | ((wdata & mask_s) << shift_s);
   end

endmodule

// File: rtl/dmem_initiator.sv
// Data-memory initiator: pipeline load/store requests to a word-wide dmem port
// with RMW sub-word stores and a wait timeout. Optional DMEM_ALIGN_CHECK_EN.
module dmem_initiator
   import leg_mem_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_re,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd,
   input  logic        mem_valid
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   dmem_init_state_e state_r;
   mem_size_e        size_r;
   logic [1:0]       addr_lo_r;
   logic             signed_r;
   logic [31:0]      wdata_r;
   logic [CNT_W-1:0] cnt_r;
   logic             misalign_s;
   logic [31:0]      load_s;
   logic [31:0]      merge_s;

   // Alignment policy for the incoming request.
   always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
      misalign_s = is_misaligned(mem_size_e'(req_size), req_addr[1:0]);
`else
      misalign_s = 1'b0;
`endif
   end

   dmem_lane_align u_align (
      .word       (mem_rd),
      .addr_lo    (addr_lo_r),
      .size       (size_r),
      .sign_ext   (signed_r),
      .wdata      (wdata_r),
      .load_data  (load_s),
      .merge_data (merge_s)
   );

   // Access FSM with wait timeout; all port outputs are registered here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         size_r     <= SZ_BYTE;
         addr_lo_r  <= 2'b00;
         signed_r   <= 1'b0;
         wdata_r    <= 32'h0;
         cnt_r      <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
         mem_re     <= 1'b0;
         mem_we     <= 1'b0;
         mem_a      <= 32'h0;
         mem_wd     <= 32'h0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  size_r    <= mem_size_e'(req_size);
                  addr_lo_r <= req_addr[1:0];
                  signed_r  <= req_signed;
                  wdata_r   <= req_wdata;
                  cnt_r     <= '0;
                  req_ready <= 1'b0;
                  mem_a     <= {req_addr[31:2], 2'b00};
                  if (misalign_s) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                     state_r    <= ST_RESP;
                  end else if (!req_write) begin
                     mem_re  <= 1'b1;
                     state_r <= ST_READ;
                  end else if (is_subword(mem_size_e'(req_size))) begin
                     mem_re  <= 1'b1;
                     state_r <= ST_RMW_RD;
                  end else begin
                     mem_we  <= 1'b1;
                     mem_wd  <= req_wdata;
                     state_r <= ST_WRITE;
                  end
               end
            end
            ST_READ, ST_RMW_RD: begin
               if (mem_valid) begin
                  mem_re <= 1'b0;
                  if (state_r == ST_READ) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_rdata <= load_s;
                     state_r    <= ST_RESP;
                  end else begin
                     mem_we  <= 1'b1;
                     mem_wd  <= merge_s;
                     cnt_r   <= '0;
                     state_r <= ST_RMW_WR;
                  end
               end else if (cnt_r == TO_LAST) begin
                  mem_re     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= 32'h0;
                  state_r    <= ST_RESP;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            ST_RMW_WR, ST_WRITE: begin
               if (mem_valid || (cnt_r == TO_LAST)) begin
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= !mem_valid;
                  resp_rdata <= 32'h0;
                  state_r    <= ST_RESP;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            ST_RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0;
               req_ready  <= 1'b1;
               state_r    <= ST_IDLE;
            end
            default: begin
               mem_re     <= 1'b0;
               mem_we     <= 1'b0;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               req_ready  <= 1'b1;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_initiator.sv
// Scoreboard bench for dmem_initiator with a programmable-wait memory responder.
module tb_dmem_initiator;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd = 32'h0;
   logic        mem_valid = 1'b0;

   dmem_initiator #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd),
      .mem_valid  (mem_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          resp_seen = 0;
   int          wait_n = 0;
   int          wcnt = 0;
   bit          never = 1'b0;
   bit          hold_we = 1'b0;
   int          re_cycles = 0;
   int          wr_count = 0;
   logic [31:0] last_wd = 32'h0;
   logic [31:0] last_wa = 32'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Memory responder: answers a strobe after wait_n cycles unless withheld.
   always @(negedge clk) begin
      if (mem_re) re_cycles++;
      if ((mem_re || mem_we) && !never && !(hold_we && mem_we)) begin
         mem_valid = (wcnt >= wait_n);
         wcnt++;
      end else begin
         mem_valid = 1'b0;
         if (!(mem_re || mem_we)) wcnt = 0;
      end
   end

   always @(posedge clk) begin
      if (mem_we && mem_valid) begin
         wr_count++;
         last_wd = mem_wd;
         last_wa = mem_a;
      end
   end

   // Monitor: strobe exclusivity every cycle, responses checked against the queue.
   always @(negedge clk) begin
      chk("strobe_excl", {31'd0, mem_re & mem_we}, 32'd0);
      if (resp_valid) begin
         resp_seen++;
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: got rdata 0x%08h err %0b with none expected", resp_rdata, resp_err);
         end else begin
            mon_e = sbq.pop_front();
            chk("resp_rdata", resp_rdata, mon_e.rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
            chk("resp_latency", cyc - mon_e.acc, mon_e.lat);
         end
      end
   end

   task automatic issue(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input bit ee, input int lat,
                        input bit push);
      exp_t e;
      @(negedge clk);
      chk("ready_before_req", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      if (push) begin
         e.rdata = er;
         e.err   = ee;
         e.lat   = lat;
         e.acc   = cyc;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string nm);
      int s;
      s = resp_seen;
      for (int i = 0; i < 60 && resp_seen == s; i++) @(negedge clk);
      total++;
      if (resp_seen == s) begin
         bad++;
         $display("FAIL %s: no response within bound, got %0d responses expected %0d", nm, resp_seen, s + 1);
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected test completion");
      $fatal(1);
   end

   initial begin
      int w0;
      int s0;
      repeat (3) @(negedge clk);
      chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
      chk("reset_mem_re", {31'd0, mem_re}, 32'd0);
      chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
      chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      reset_n = 1'b1;

      // Word load, zero wait.
      mem_rd = 32'hDEAD_BEEF;
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b1);
      @(negedge clk);
      chk("load_mem_re_c1", {31'd0, mem_re}, 32'd1);
      chk("load_mem_a_c1", mem_a, 32'h0000_0100);
      wait_resp("word_load");

      // Byte and half loads with extension.
      mem_rd = 32'h80FF_0000;
      issue(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1'b1);
      wait_resp("sbyte_load");
      issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h0000_0080, 1'b0, 2, 1'b1);
      wait_resp("ubyte_load");
      mem_rd = 32'h8001_7FFF;
      issue(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'hFFFF_8001, 1'b0, 2, 1'b1);
      wait_resp("shalf_load");
      issue(1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 32'h0000_7FFF, 1'b0, 2, 1'b1);
      wait_resp("half_load_pos");

      // Sub-word stores via read-modify-write, then a direct word store.
      mem_rd = 32'h1122_3344;
      w0 = wr_count;
      issue(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 1'b0, 3, 1'b1);
      wait_resp("half_store");
      chk("half_store_count", wr_count - w0, 32'd1);
      chk("half_store_wd", last_wd, 32'hBEEF_3344);
      chk("half_store_wa", last_wa, 32'h0000_0200);
      issue(1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'hFFFF_FFAB, 32'h0, 1'b0, 3, 1'b1);
      wait_resp("byte_store");
      chk("byte_store_wd", last_wd, 32'h1122_AB44);
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1'b1);
      wait_resp("word_store");
      chk("word_store_wd", last_wd, 32'hCAFE_F00D);
      chk("word_store_wa", last_wa, 32'h0000_0300);

      // Wait states, then timeouts on a load and on an RMW read.
      wait_n = 3;
      re_cycles = 0;
      mem_rd = 32'h1234_5678;
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'h1234_5678, 1'b0, 5, 1'b1);
      wait_resp("wait3_load");
      chk("wait3_re_cycles", re_cycles, 32'd4);
      wait_n = 0;
      never = 1'b1;
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0108, 32'h0, 32'h0, 1'b1, 17, 1'b1);
      wait_resp("timeout_load");
      w0 = wr_count;
      issue(1'b1, 2'b01, 1'b0, 32'h0000_0110, 32'h0000_1234, 32'h0, 1'b1, 17, 1'b1);
      wait_resp("timeout_rmw");
      chk("timeout_rmw_no_write", wr_count - w0, 32'd0);
      never = 1'b0;

      // Reset while the RMW write is pending.
      hold_we = 1'b1;
      mem_rd = 32'h1122_3344;
      s0 = resp_seen;
      issue(1'b1, 2'b00, 1'b0, 32'h0000_0205, 32'h0000_0055, 32'h0, 1'b0, 0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("rmw_wr_mem_we", {31'd0, mem_we}, 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("reset_drops_we", {31'd0, mem_we}, 32'd0);
      chk("reset_drops_re", {31'd0, mem_re}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      hold_we = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", {31'd0, req_ready}, 32'd1);
      repeat (5) @(negedge clk);
      chk("post_reset_no_resp", resp_seen - s0, 32'd0);

      // Misaligned word load.
      mem_rd = 32'hA5A5_5A5A;
      re_cycles = 0;
`ifdef DMEM_ALIGN_CHECK_EN
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 1'b1, 1, 1'b1);
      wait_resp("misalign_err");
      chk("misalign_no_re", re_cycles, 32'd0);
`else
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 32'hA5A5_5A5A, 1'b0, 2, 1'b1);
      @(negedge clk);
      chk("misalign_mem_a", mem_a, 32'h0000_0100);
      wait_resp("misalign_read");
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
